util_watch_dog_mc: RTL and testbench

Multi-channel, parametrised successor to the single-channel watchdog. Each of CH channels has its own counter that reloads on monitor activity and decrements on a shared tick (`cnt_pulse`); a channel that sees no activity for its preset number of ticks times out. Adds selectable edge/level activity detection per channel, an aggregated interrupt, and an optional early-kick window check. Sits beside link/heartbeat monitors, feeding status registers and the interrupt controller.

---
 rtl/util_watch_dog_pkg.sv | 14 +
 rtl/util_watch_dog_ch.sv | 136 +++++++++++++
 rtl/util_watch_dog_mc.sv | 78 +++++++
 tb/tb_util_watch_dog_mc.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/util_watch_dog_pkg.sv
// Shared definitions for the multi-channel watchdog: channel state encoding
// and default parameter values.
// Optional build macro: WATCH_DOG_WINDOW_EN (early-kick window check).
package util_watch_dog_pkg;

    localparam int WD_CNT_W_DEFAULT = 32;
    localparam int WD_CH_DEFAULT    = 4;

    typedef enum logic {
        WD_IDLE  = 1'b0,
        WD_ALIVE = 1'b1
    } wd_state_e;

endpackage

// File: rtl/util_watch_dog_ch.sv
// One watchdog channel: activity detection (edge or level), reloadable
// down-counter driven by the shared tick, alive/timeout pulses and, when
// WATCH_DOG_WINDOW_EN is defined, the early-kick window check with a sticky
// fault bit.
module util_watch_dog_ch
    import util_watch_dog_pkg::*;
#(
    parameter int CNT_W = WD_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             edge_mode,
    input  logic [CNT_W-1:0] preset,
    input  logic             monitor_in,
    input  logic             cnt_pulse,
`ifdef WATCH_DOG_WINDOW_EN
    input  logic             clear,
    input  logic [CNT_W-1:0] win,
    output logic             fault,
`endif
    output logic             state,
    output logic             active,
    output logic             inactive
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic             prevMon_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    wd_state_e        state_q, state_d;
    logic             active_q, active_d;
    logic             inactive_q, inactive_d;
    logic             actEvent;
    logic             loadEvent;
    logic             earlyKick;

    // Activity is a rising edge or a high level; a zero preset makes it inert.
    always_comb begin
        actEvent  = edge_mode ? (monitor_in & ~prevMon_q) : monitor_in;
        loadEvent = actEvent & (preset != '0);
    end

`ifdef WATCH_DOG_WINDOW_EN
    logic [CNT_W-1:0] ld_q, ld_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] elapsed;

    // A kick that arrives fewer than win ticks after the last reload is early.
    always_comb begin
        elapsed   = ld_q - cnt_q;
        earlyKick = loadEvent & (state_q == WD_ALIVE) & (win != '0) & (elapsed < win);
    end

    // Remember the reload value and keep the sticky fault; setting beats clearing.
    always_comb begin
        ld_d    = ld_q;
        fault_d = fault_q & ~clear;
        if (!en) begin
            fault_d = 1'b0;
        end else begin
            if (loadEvent && !earlyKick) begin
                ld_d = preset;
            end
            if (earlyKick) begin
                fault_d = 1'b1;
            end
        end
    end

    // Window bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            ld_q    <= ld_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign earlyKick = 1'b0;
`endif

    // Next-state: disable beats early kick beats reload beats tick decrement.
    always_comb begin
        cnt_d      = cnt_q;
        state_d    = state_q;
        active_d   = 1'b0;
        inactive_d = 1'b0;
        if (!en) begin
            cnt_d   = '0;
            state_d = WD_IDLE;
        end else if (earlyKick) begin
            cnt_d      = '0;
            state_d    = WD_IDLE;
            inactive_d = 1'b1;
        end else if (loadEvent) begin
            cnt_d    = preset;
            state_d  = WD_ALIVE;
            active_d = (state_q == WD_IDLE);
        end else if (cnt_pulse && (cnt_q != '0)) begin
            if (cnt_q == CntOne) begin
                cnt_d      = '0;
                state_d    = WD_IDLE;
                inactive_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CntOne;
            end
        end
    end

    // Channel registers; the monitor history is kept even while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            prevMon_q  <= 1'b0;
            cnt_q      <= '0;
            state_q    <= WD_IDLE;
            active_q   <= 1'b0;
            inactive_q <= 1'b0;
        end else begin
            prevMon_q  <= monitor_in;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            active_q   <= active_d;
            inactive_q <= inactive_d;
        end
    end

    assign state    = (state_q == WD_ALIVE);
    assign active   = active_q;
    assign inactive = inactive_q;

endmodule

// File: rtl/util_watch_dog_mc.sv
// Multi-channel watchdog top: CH independent channels sharing one tick, plus
// the aggregated interrupt and the all-channels-alive summary.
// Optional build macro: WATCH_DOG_WINDOW_EN adds win/fault ports and makes
// clear meaningful.
module util_watch_dog_mc
    import util_watch_dog_pkg::*;
#(
    parameter int CH    = WD_CH_DEFAULT,
    parameter int CNT_W = WD_CNT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       en,
    input  logic [CH-1:0]       edge_mode,
    input  logic [CH*CNT_W-1:0] preset,
    input  logic [CH-1:0]       monitor_in,
    input  logic                cnt_pulse,
    input  logic [CH-1:0]       clear,
`ifdef WATCH_DOG_WINDOW_EN
    input  logic [CH*CNT_W-1:0] win,
    output logic [CH-1:0]       fault,
`endif
    output logic [CH-1:0]       state,
    output logic [CH-1:0]       active,
    output logic [CH-1:0]       inactive,
    output logic                all_alive,
    output logic                irq
);

    logic [CH-1:0] en_q;
    logic          irq_q;

`ifndef WATCH_DOG_WINDOW_EN
    logic unusedClear;
    assign unusedClear = ^clear;
`endif

    for (genvar i = 0; i < CH; i++) begin : gCh
        util_watch_dog_ch #(
            .CNT_W(CNT_W)
        ) uCh (
            .clk       (clk),
            .rst       (rst),
            .en        (en[i]),
            .edge_mode (edge_mode[i]),
            .preset    (preset[i*CNT_W +: CNT_W]),
            .monitor_in(monitor_in[i]),
            .cnt_pulse (cnt_pulse),
`ifdef WATCH_DOG_WINDOW_EN
            .clear     (clear[i]),
            .win       (win[i*CNT_W +: CNT_W]),
            .fault     (fault[i]),
`endif
            .state     (state[i]),
            .active    (active[i]),
            .inactive  (inactive[i])
        );
    end

    // Registered enables feed all_alive and irq follows any timeout by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            en_q  <= en;
            irq_q <= |inactive;
        end
    end

    // A disabled channel never holds all_alive low.
    always_comb begin
        all_alive = &(state | ~en_q);
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_util_watch_dog_mc.sv
// Scoreboard bench for util_watch_dog_mc: a tick-level reference model
// pushes the expected outputs for every cycle, and an independent monitor
// compares them against the DUT shortly after each rising edge.
// Honours WATCH_DOG_WINDOW_EN when the design is built with it.
module tb_util_watch_dog_mc;

   localparam int CH    = 4;
   localparam int CNT_W = 16;

   typedef struct packed {
      logic [CH-1:0] state;
      logic [CH-1:0] active;
      logic [CH-1:0] inactive;
      logic [CH-1:0] fault;
      logic          allAlive;
      logic          irq;
   } exp_t;

   logic                clock = 1'b0;
   logic                rst;
   logic [CH-1:0]       en;
   logic [CH-1:0]       edgeMode;
   logic [CH*CNT_W-1:0] preset;
   logic [CH-1:0]       monitorIn;
   logic                cntPulse;
   logic [CH-1:0]       clear;
   logic [CH-1:0]       state;
   logic [CH-1:0]       active;
   logic [CH-1:0]       inactive;
   logic                allAlive;
   logic                irq;
`ifdef WATCH_DOG_WINDOW_EN
   logic [CH*CNT_W-1:0] win;
   logic [CH-1:0]       fault;
`endif

   exp_t expQ[$];
   int   checksTotal  = 0;
   int   checksPassed = 0;

   // Reference model: remaining ticks per channel and the value last loaded.
   int   mRemain[CH];
   int   mLoaded[CH];
   bit   mPrevMon[CH];
   bit   mFault[CH];
   bit   mTimedOut[CH];
   bit   mEnSeen[CH];

   always #5 clock = ~clock;

   util_watch_dog_mc #(
      .CH   (CH),
      .CNT_W(CNT_W)
   ) dut (
      .clk       (clock),
      .rst       (rst),
      .en        (en),
      .edge_mode (edgeMode),
      .preset    (preset),
      .monitor_in(monitorIn),
      .cnt_pulse (cntPulse),
      .clear     (clear),
`ifdef WATCH_DOG_WINDOW_EN
      .win       (win),
      .fault     (fault),
`endif
      .state     (state),
      .active    (active),
      .inactive  (inactive),
      .all_alive (allAlive),
      .irq       (irq)
   );

   // Compare one field and record the outcome.
   task automatic checkField(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checksTotal++;
      if (actual !== expected)
         $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, actual, expected);
      else
         checksPassed++;
   endtask

   // Compare every DUT output against one scoreboard entry.
   task automatic checkOutput(input exp_t e);
      checkField("state", 32'(state), 32'(e.state));
      checkField("active", 32'(active), 32'(e.active));
      checkField("inactive", 32'(inactive), 32'(e.inactive));
      checkField("all_alive", 32'(allAlive), 32'(e.allAlive));
      checkField("irq", 32'(irq), 32'(e.irq));
`ifdef WATCH_DOG_WINDOW_EN
      checkField("fault", 32'(fault), 32'(e.fault));
`endif
   endtask

   // Advance the reference model by one clock using the current inputs,
   // queue the outcome, then move to the next driving point.
   task automatic applyStimulus();
      exp_t e;
      bit   anyTimeout;
      bit   ev;
      bit   early;
      int   p;
      int   w;
      e = '0;
      anyTimeout = 0;
      for (int i = 0; i < CH; i++) if (mTimedOut[i]) anyTimeout = 1;
      for (int i = 0; i < CH; i++) begin
         if (rst) begin
            mRemain[i] = 0; mLoaded[i] = 0; mPrevMon[i] = 0;
            mFault[i] = 0; mTimedOut[i] = 0; mEnSeen[i] = 0;
         end else begin
            p = int'(preset[i*CNT_W +: CNT_W]);
            w = 0;
`ifdef WATCH_DOG_WINDOW_EN
            w = int'(win[i*CNT_W +: CNT_W]);
`endif
            ev = edgeMode[i] ? (monitorIn[i] && !mPrevMon[i]) : monitorIn[i];
            mPrevMon[i] = monitorIn[i];
            mTimedOut[i] = 0;
            early = 0;
            if (!en[i]) begin
               mRemain[i] = 0;
               mFault[i] = 0;
            end else begin
               if (ev && p != 0 && mRemain[i] > 0 && w != 0 && (mLoaded[i] - mRemain[i]) < w) early = 1;
               if (early) begin
                  mRemain[i] = 0;
                  mTimedOut[i] = 1;
               end else if (ev && p != 0) begin
                  if (mRemain[i] == 0) e.active[i] = 1'b1;
                  mRemain[i] = p;
                  mLoaded[i] = p;
               end else if (cntPulse && mRemain[i] > 0) begin
                  mRemain[i] = mRemain[i] - 1;
                  if (mRemain[i] == 0) mTimedOut[i] = 1;
               end
`ifdef WATCH_DOG_WINDOW_EN
               if (early) mFault[i] = 1;
               else if (clear[i]) mFault[i] = 0;
`endif
            end
            mEnSeen[i] = en[i];
         end
         e.state[i]    = (mRemain[i] > 0);
         e.inactive[i] = mTimedOut[i];
         e.fault[i]    = mFault[i];
      end
      e.irq = rst ? 1'b0 : anyTimeout;
      e.allAlive = 1'b1;
      for (int i = 0; i < CH; i++) if (!(mRemain[i] > 0) && mEnSeen[i]) e.allAlive = 1'b0;
      expQ.push_back(e);
      @(negedge clock);
   endtask

   task automatic runCycles(input int n);
      for (int k = 0; k < n; k++) applyStimulus();
   endtask

   task automatic setPreset(input int ch, input int value);
      preset[ch*CNT_W +: CNT_W] = CNT_W'(value);
   endtask

   // Monitor: pop and compare one expectation after every rising edge.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (expQ.size() > 0) checkOutput(expQ.pop_front());
      end
   end

   // Stimulus: directed scenarios followed by randomized traffic.
   initial begin
      rst = 1'b1; en = '1; edgeMode = '1; monitorIn = '1; cntPulse = 1'b1; clear = '1;
      preset = '0;
      for (int i = 0; i < CH; i++) setPreset(i, 5);
`ifdef WATCH_DOG_WINDOW_EN
      win = '0;
      for (int i = 0; i < CH; i++) win[i*CNT_W +: CNT_W] = CNT_W'(2);
`endif
      @(negedge clock);
      runCycles(2);

      rst = 1'b0; clear = '0; monitorIn = '0; edgeMode = 4'b1101;
`ifdef WATCH_DOG_WINDOW_EN
      win = '0;
`endif
      setPreset(0, 8); setPreset(1, 4); setPreset(2, 6); setPreset(3, 0);
      runCycles(2);

      // Single rising edge on channel 0, then let it time out.
      monitorIn[0] = 1'b1; runCycles(1);
      monitorIn[0] = 1'b0; runCycles(12);

      // Level keep-alive on channel 1, then release.
      monitorIn[1] = 1'b1; runCycles(100);
      monitorIn[1] = 1'b0; runCycles(8);

      // Tick every third cycle on channel 0 with preset 5, plus a collision.
      setPreset(0, 5);
      for (int c = 0; c < 24; c++) begin
         cntPulse = (c % 3 == 2);
         monitorIn[0] = (c == 0) || (c == 11);
         applyStimulus();
      end
      monitorIn[0] = 1'b0;
      for (int c = 0; c < 18; c++) begin
         cntPulse = (c % 3 == 2);
         applyStimulus();
      end
      cntPulse = 1'b1;

      // Disable channel 2 mid-count; zero preset on channel 3.
      monitorIn[2] = 1'b1; runCycles(1);
      monitorIn[2] = 1'b0; runCycles(3);
      en[2] = 1'b0; runCycles(3);
      en[2] = 1'b1; runCycles(8);
      for (int c = 0; c < 6; c++) begin
         monitorIn[3] = ~monitorIn[3];
         applyStimulus();
      end
      monitorIn[3] = 1'b0; runCycles(2);

`ifdef WATCH_DOG_WINDOW_EN
      // Early kick 3 ticks after a reload, sticky fault, clear, then a late kick.
      setPreset(0, 20); win[0 +: CNT_W] = CNT_W'(5);
      monitorIn[0] = 1'b1; runCycles(1);
      monitorIn[0] = 1'b0; runCycles(2);
      monitorIn[0] = 1'b1; runCycles(1);
      monitorIn[0] = 1'b0; runCycles(6);
      clear[0] = 1'b1; runCycles(1);
      clear[0] = 1'b0;
      monitorIn[0] = 1'b1; runCycles(1);
      monitorIn[0] = 1'b0; runCycles(5);
      monitorIn[0] = 1'b1; runCycles(1);
      monitorIn[0] = 1'b0; runCycles(25);
`endif

      // Randomized traffic in a few phases with fresh per-channel settings.
      for (int ph = 0; ph < 4; ph++) begin
         for (int i = 0; i < CH; i++) begin
            edgeMode[i] = 1'($urandom_range(0, 1));
            setPreset(i, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 10)));
`ifdef WATCH_DOG_WINDOW_EN
            win[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 6));
`endif
         end
         for (int c = 0; c < 600; c++) begin
            cntPulse = 1'($urandom_range(0, 1));
            for (int i = 0; i < CH; i++) begin
               en[i]        = ($urandom_range(0, 31) != 0);
               monitorIn[i] = ($urandom_range(0, 7) == 0);
               clear[i]     = ($urandom_range(0, 15) == 0);
            end
            rst = ($urandom_range(0, 499) == 0);
            applyStimulus();
         end
         rst = 1'b0;
      end

      // Drain the scoreboard within a bounded number of cycles.
      for (int k = 0; k < 5 && expQ.size() > 0; k++) @(negedge clock);
      if (expQ.size() > 0) begin
         checksTotal++;
         $display("[TB] FAIL drain: %0d entries left expected 0", expQ.size());
      end

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
